soml_input_loader: RTL and testbench

//  Upstream stage of soml_decoder_top. Captures one frame: a streamed 4x4 complex channel

---
 rtl/soml_pkg.sv | 21 ++
 rtl/soml_frame_bank.sv | 67 ++++++
 rtl/soml_input_loader.sv | 182 ++++++++++++++++++
 tb/tb_soml_input_loader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soml_pkg.sv
// Shared constants and types for the SOML input loader and its frame bank.
// The loader's optional protocol checker is enabled with SOML_LOADER_ERR_EN.
package soml_pkg;

  localparam int SOML_N    = 32;
  localparam int SOML_ROWS = 4;
  localparam int SOML_COLS = 4;
  localparam int SOML_YLEN = 8;
  localparam int SOML_HLEN = SOML_ROWS * SOML_COLS;

  typedef struct packed {
    logic signed [SOML_N-1:0] re;
    logic signed [SOML_N-1:0] im;
  } cplx_t;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_t;

endpackage : soml_pkg

// File: rtl/soml_frame_bank.sv
// One frame of storage: H (row-major, flat index) and Y, each split into real/imag.
// Single-entry write per stream per cycle, combinational random-access read.
module soml_frame_bank
  import soml_pkg::*;
#(
  parameter int N    = SOML_N,
  parameter int HLEN = SOML_HLEN,
  parameter int YLEN = SOML_YLEN,
  parameter int HAW  = $clog2(HLEN),
  parameter int YAW  = $clog2(YLEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                h_we,
  input  logic [HAW-1:0]      h_waddr,
  input  logic signed [N-1:0] h_wr,
  input  logic signed [N-1:0] h_wi,
  input  logic                y_we,
  input  logic [YAW-1:0]      y_waddr,
  input  logic signed [N-1:0] y_wr,
  input  logic signed [N-1:0] y_wi,
  input  logic [HAW-1:0]      h_raddr,
  input  logic [YAW-1:0]      y_raddr,
  output logic signed [N-1:0] h_rr,
  output logic signed [N-1:0] h_ri,
  output logic signed [N-1:0] y_rr,
  output logic signed [N-1:0] y_ri
);

  logic signed [N-1:0] h_re_mem [HLEN];
  logic signed [N-1:0] h_im_mem [HLEN];
  logic signed [N-1:0] y_re_mem [YLEN];
  logic signed [N-1:0] y_im_mem [YLEN];

  // Storage must read back as zero after reset, so each entry is a plain register.
  generate
    for (genvar gi = 0; gi < HLEN; gi++) begin : g_h
      always_ff @(posedge clk) begin
        if (rst) begin
          h_re_mem[gi] <= '0;
          h_im_mem[gi] <= '0;
        end else if (h_we && (h_waddr == HAW'(gi))) begin
          h_re_mem[gi] <= h_wr;
          h_im_mem[gi] <= h_wi;
        end
      end
    end

    for (genvar gi = 0; gi < YLEN; gi++) begin : g_y
      always_ff @(posedge clk) begin
        if (rst) begin
          y_re_mem[gi] <= '0;
          y_im_mem[gi] <= '0;
        end else if (y_we && (y_waddr == YAW'(gi))) begin
          y_re_mem[gi] <= y_wr;
          y_im_mem[gi] <= y_wi;
        end
      end
    end
  endgenerate

  assign h_rr = h_re_mem[h_raddr];
  assign h_ri = h_im_mem[h_raddr];
  assign y_rr = y_re_mem[y_raddr];
  assign y_ri = y_im_mem[y_raddr];

endmodule : soml_frame_bank

// File: rtl/soml_input_loader.sv
// Ping-pong frame loader: captures H (ROWS x COLS) and Y (YLEN) streams into the write
// bank and hands complete frames to the decoder. Optional checker: SOML_LOADER_ERR_EN.
module soml_input_loader
  import soml_pkg::*;
#(
  parameter int N    = SOML_N,
  parameter int ROWS = SOML_ROWS,
  parameter int COLS = SOML_COLS,
  parameter int YLEN = SOML_YLEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        H_in_valid,
  input  logic signed [N-1:0]         H_in_r,
  input  logic signed [N-1:0]         H_in_i,
  input  logic                        Y_in_valid,
  input  logic signed [N-1:0]         Y_in_r,
  input  logic signed [N-1:0]         Y_in_i,
  output logic                        loading,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  input  logic [$clog2(ROWS)-1:0]     h_rd_row,
  input  logic [$clog2(COLS)-1:0]     h_rd_col,
  output logic signed [N-1:0]         h_rd_r,
  output logic signed [N-1:0]         h_rd_i,
  input  logic [$clog2(YLEN)-1:0]     y_rd_addr,
  output logic signed [N-1:0]         y_rd_r,
  output logic signed [N-1:0]         y_rd_i,
  output logic                        err
);

  localparam int HLEN = ROWS * COLS;
  localparam int HCW  = $clog2(HLEN + 1);
  localparam int YCW  = $clog2(YLEN + 1);
  localparam int HAW  = $clog2(HLEN);
  localparam int YAW  = $clog2(YLEN);

  ld_state_t        state_reg;
  logic [HCW-1:0]   h_cnt_reg;
  logic [YCW-1:0]   y_cnt_reg;
  logic [1:0]       full_reg;
  logic             wr_bank_reg;
  logic             rd_bank_reg;

  logic             in_load;
  logic             start_ok;
  logic             restart;
  logic             h_cap;
  logic             y_cap;
  logic [HCW-1:0]   h_cnt_next;
  logic [YCW-1:0]   y_cnt_next;
  logic             frame_done;
  logic             release_rd;
  logic [1:0]       full_next;
  logic [HAW-1:0]   h_raddr;

  assign in_load  = (state_reg == LD_LOAD);
  assign start_ok = start && !in_load && !full_reg[wr_bank_reg];
  assign restart  = start && in_load;

  // A restart cycle discards the partial frame, including any beat presented with it.
  assign h_cap = in_load && !start && H_in_valid && (h_cnt_reg != HCW'(HLEN));
  assign y_cap = in_load && !start && Y_in_valid && (y_cnt_reg != YCW'(YLEN));

  assign h_cnt_next = h_cnt_reg + HCW'(h_cap);
  assign y_cnt_next = y_cnt_reg + YCW'(y_cap);
  assign frame_done = in_load && !start
                   && (h_cnt_next == HCW'(HLEN)) && (y_cnt_next == YCW'(YLEN));

  assign release_rd = full_reg[rd_bank_reg] && frame_ready;

  // Completion and release always target different banks: the write bank is never full.
  always_comb begin
    full_next = full_reg;
    if (release_rd) full_next[rd_bank_reg] = 1'b0;
    if (frame_done) full_next[wr_bank_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LD_IDLE;
      h_cnt_reg   <= '0;
      y_cnt_reg   <= '0;
      full_reg    <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (release_rd) rd_bank_reg <= ~rd_bank_reg;

      case (state_reg)
        LD_IDLE: begin
          if (start_ok) begin
            state_reg <= LD_LOAD;
            h_cnt_reg <= '0;
            y_cnt_reg <= '0;
          end
        end
        LD_LOAD: begin
          if (restart) begin
            h_cnt_reg <= '0;
            y_cnt_reg <= '0;
          end else if (frame_done) begin
            state_reg   <= LD_IDLE;
            h_cnt_reg   <= '0;
            y_cnt_reg   <= '0;
            wr_bank_reg <= ~wr_bank_reg;
          end else begin
            h_cnt_reg <= h_cnt_next;
            y_cnt_reg <= y_cnt_next;
          end
        end
        default: state_reg <= LD_IDLE;
      endcase
    end
  end

  assign loading     = in_load;
  assign frame_valid = full_reg[rd_bank_reg];

  assign h_raddr = HAW'(h_rd_row) * HAW'(COLS) + HAW'(h_rd_col);

  logic signed [N-1:0] bank_h_rr [2];
  logic signed [N-1:0] bank_h_ri [2];
  logic signed [N-1:0] bank_y_rr [2];
  logic signed [N-1:0] bank_y_ri [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      soml_frame_bank #(
        .N    (N),
        .HLEN (HLEN),
        .YLEN (YLEN),
        .HAW  (HAW),
        .YAW  (YAW)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .h_we    (h_cap && (wr_bank_reg == 1'(gi))),
        .h_waddr (h_cnt_reg[HAW-1:0]),
        .h_wr    (H_in_r),
        .h_wi    (H_in_i),
        .y_we    (y_cap && (wr_bank_reg == 1'(gi))),
        .y_waddr (y_cnt_reg[YAW-1:0]),
        .y_wr    (Y_in_r),
        .y_wi    (Y_in_i),
        .h_raddr (h_raddr),
        .y_raddr (y_rd_addr),
        .h_rr    (bank_h_rr[gi]),
        .h_ri    (bank_h_ri[gi]),
        .y_rr    (bank_y_rr[gi]),
        .y_ri    (bank_y_ri[gi])
      );
    end
  endgenerate

  assign h_rd_r = bank_h_rr[rd_bank_reg];
  assign h_rd_i = bank_h_ri[rd_bank_reg];
  assign y_rd_r = bank_y_rr[rd_bank_reg];
  assign y_rd_i = bank_y_ri[rd_bank_reg];

`ifdef SOML_LOADER_ERR_EN
  logic err_reg;
  logic err_event;

  assign err_event = (start && !in_load && full_reg[wr_bank_reg])
                  || restart
                  || (H_in_valid && !h_cap)
                  || (Y_in_valid && !y_cap);

  always_ff @(posedge clk) begin
    if (rst) err_reg <= 1'b0;
    else if (err_event) err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule : soml_input_loader

// File: tb/tb_soml_input_loader.sv
// Scenario bench for soml_input_loader: frames are pushed to a scoreboard when driven
// and compared against the read ports whenever the DUT presents a frame.
module tb_soml_input_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        H_in_valid = 1'b0;
  logic [31:0] H_in_r = '0;
  logic [31:0] H_in_i = '0;
  logic        Y_in_valid = 1'b0;
  logic [31:0] Y_in_r = '0;
  logic [31:0] Y_in_i = '0;
  logic        loading;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [1:0]  h_rd_row = '0;
  logic [1:0]  h_rd_col = '0;
  logic [31:0] h_rd_r;
  logic [31:0] h_rd_i;
  logic [2:0]  y_rd_addr = '0;
  logic [31:0] y_rd_r;
  logic [31:0] y_rd_i;
  logic        err;

  soml_input_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .H_in_valid  (H_in_valid),
    .H_in_r      (H_in_r),
    .H_in_i      (H_in_i),
    .Y_in_valid  (Y_in_valid),
    .Y_in_r      (Y_in_r),
    .Y_in_i      (Y_in_i),
    .loading     (loading),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .h_rd_row    (h_rd_row),
    .h_rd_col    (h_rd_col),
    .h_rd_r      (h_rd_r),
    .h_rd_i      (h_rd_i),
    .y_rd_addr   (y_rd_addr),
    .y_rd_r      (y_rd_r),
    .y_rd_i      (y_rd_i),
    .err         (err)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic [15:0][31:0] hr;
    logic [15:0][31:0] hi;
    logic [7:0][31:0]  yr;
    logic [7:0][31:0]  yi;
  } frame_t;

  frame_t sb[$];
  int     checks = 0;
  int     errors = 0;
  logic   exp_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t make_frame(input logic [31:0] base);
    frame_t f;
    for (int n = 0; n < 16; n++) begin
      f.hr[n] = base + 32'h0000_0100 * (n + 1);
      f.hi[n] = $urandom;
    end
    for (int k = 0; k < 8; k++) begin
      f.yr[k] = $urandom;
      f.yi[k] = $urandom;
    end
    return f;
  endfunction

  task automatic beat(input logic hv, input logic [31:0] hr, input logic [31:0] hi,
                      input logic yv, input logic [31:0] yr, input logic [31:0] yi);
    H_in_valid = hv; H_in_r = hr; H_in_i = hi;
    Y_in_valid = yv; Y_in_r = yr; Y_in_i = yi;
    tick();
    H_in_valid = 1'b0;
    Y_in_valid = 1'b0;
  endtask

  // Start pulse, 16 H beats, 8 Y beats beginning at H beat y_start; optionally releases
  // the current read frame on the last beat.
  task automatic drive_frame(input frame_t f, input int y_start, input logic ready_last);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      frame_ready = ready_last && (c == 15);
      beat(1'b1, f.hr[c], f.hi[c], (c >= y_start) && (c < y_start + 8),
           f.yr[(c - y_start) & 7], f.yi[(c - y_start) & 7]);
    end
    frame_ready = 1'b0;
    if (ready_last && sb.size() > 0) void'(sb.pop_front());
    sb.push_back(f);
  endtask

  task automatic check_head(input string name);
    frame_t f;
    checks++;
    if (sb.size() == 0 || frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s head: frame_valid=%0b queued=%0d, required frame_valid=1 with a queued frame",
               name, frame_valid, sb.size());
    end else begin
      f = sb[0];
      for (int n = 0; n < 16; n++) begin
        h_rd_row = 2'(n >> 2);
        h_rd_col = 2'(n & 3);
        #1;
        checks++;
        if (h_rd_r !== f.hr[n] || h_rd_i !== f.hi[n]) begin
          errors++;
          $display("FAIL %s H[%0d][%0d]: got %h/%h, required %h/%h",
                   name, n >> 2, n & 3, h_rd_r, h_rd_i, f.hr[n], f.hi[n]);
        end
      end
      for (int k = 0; k < 8; k++) begin
        y_rd_addr = 3'(k);
        #1;
        checks++;
        if (y_rd_r !== f.yr[k] || y_rd_i !== f.yi[k]) begin
          errors++;
          $display("FAIL %s Y[%0d]: got %h/%h, required %h/%h",
                   name, k, y_rd_r, y_rd_i, f.yr[k], f.yi[k]);
        end
      end
      $display("frame %s: compared 16 H + 8 Y entries", name);
    end
  endtask

  task automatic release_head(input string name);
    logic exp_valid;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    exp_valid = (sb.size() > 0);
    checks++;
    if (frame_valid !== exp_valid) begin
      errors++;
      $display("FAIL %s release: frame_valid=%0b, required %0b", name, frame_valid, exp_valid);
    end else begin
      $display("release %s: frame_valid=%0b", name, frame_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    h_rd_row = 2'd0; h_rd_col = 2'd0; y_rd_addr = 3'd0;
    #1;
    checks++;
    if (loading !== 1'b0 || frame_valid !== 1'b0 || err !== 1'b0 ||
        h_rd_r !== 32'd0 || y_rd_r !== 32'd0) begin
      errors++;
      $display("FAIL reset: loading=%0b frame_valid=%0b err=%0b h=%h y=%h, required all 0",
               loading, frame_valid, err, h_rd_r, y_rd_r);
    end else $display("reset: outputs idle");
  endtask

  task automatic test_basic();
    frame_t f;
    f = make_frame(32'd0);
    drive_frame(f, 8, 1'b0);
    checks++;
    if (frame_valid !== 1'b1 || loading !== 1'b0) begin
      errors++;
      $display("FAIL basic done: frame_valid=%0b loading=%0b, required 1/0", frame_valid, loading);
    end
    h_rd_row = 2'd2; h_rd_col = 2'd3; y_rd_addr = 3'd7;
    #1;
    checks++;
    if (h_rd_r !== 32'h0000_0C00) begin
      errors++;
      $display("FAIL basic H[2][3]: got %h, required 00000c00", h_rd_r);
    end
    checks++;
    if (y_rd_r !== f.yr[7] || y_rd_i !== f.yi[7]) begin
      errors++;
      $display("FAIL basic Y[7]: got %h/%h, required %h/%h", y_rd_r, y_rd_i, f.yr[7], f.yi[7]);
    end
    check_head("basic");
    release_head("basic");
  endtask

  task automatic test_y_early();
    frame_t f;
    f = make_frame(32'h1000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      beat(1'b1, f.hr[c], f.hi[c], c < 8, f.yr[c % 8], f.yi[c % 8]);
      if (c == 14) begin
        checks++;
        if (frame_valid !== 1'b0 || loading !== 1'b1) begin
          errors++;
          $display("FAIL y_early wait: frame_valid=%0b loading=%0b, required 0/1", frame_valid, loading);
        end
      end
    end
    sb.push_back(f);
    checks++;
    if (frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL y_early done: frame_valid=%0b, required 1", frame_valid);
    end
    beat(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
`ifdef SOML_LOADER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL y_early err: got %0b, required %0b", err, exp_err);
    end
    check_head("y_early");
    release_head("y_early");
  endtask

  task automatic test_both_full();
    frame_t a;
    frame_t b;
    a = make_frame(32'h2000_0000);
    b = make_frame(32'h3000_0000);
    drive_frame(a, 4, 1'b0);
    drive_frame(b, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (loading !== 1'b0 || frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL both_full start: loading=%0b frame_valid=%0b, required 0/1", loading, frame_valid);
    end
    check_head("both_full_A");
    release_head("both_full_A");
    check_head("both_full_B");
    release_head("both_full_B");
  endtask

  task automatic test_restart();
    frame_t c;
    c = make_frame(32'h4000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 5; n++)
      beat(1'b1, 32'hBAD0_0000 + n, 32'hBAD1_0000 + n, n < 3, 32'hBAD2_0000 + n, 32'hBAD3_0000 + n);
    checks++;
    if (loading !== 1'b1) begin
      errors++;
      $display("FAIL restart partial: loading=%0b, required 1", loading);
    end
    drive_frame(c, 2, 1'b0);
    check_head("restart");
    release_head("restart");
  endtask

  task automatic test_simul_release();
    frame_t a;
    frame_t b;
    frame_t d;
    a = make_frame(32'h5000_0000);
    b = make_frame(32'h6000_0000);
    d = make_frame(32'h7000_0000);
    drive_frame(a, 8, 1'b0);
    check_head("simul_A");
    drive_frame(b, 8, 1'b1);
    checks++;
    if (frame_valid !== 1'b1 || loading !== 1'b0) begin
      errors++;
      $display("FAIL simul done: frame_valid=%0b loading=%0b, required 1/0", frame_valid, loading);
    end
    check_head("simul_B");
    drive_frame(d, 3, 1'b0);
    release_head("simul_B");
    check_head("simul_D");
    release_head("simul_D");
  endtask

  task automatic test_rst_midload();
    frame_t x;
    frame_t z;
    x = make_frame(32'h8000_0000);
    z = make_frame(32'h9000_0000);
    drive_frame(x, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 4; n++)
      beat(1'b1, 32'h1234_0000 + n, 32'h5678_0000 + n, 1'b1, 32'h9ABC_0000 + n, 32'hDEF0_0000 + n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    h_rd_row = 2'd0; h_rd_col = 2'd0; y_rd_addr = 3'd0;
    #1;
    checks++;
    if (loading !== 1'b0 || frame_valid !== 1'b0 || err !== 1'b0 ||
        h_rd_r !== 32'd0 || y_rd_r !== 32'd0) begin
      errors++;
      $display("FAIL rst_midload: loading=%0b frame_valid=%0b err=%0b h=%h y=%h, required all 0",
               loading, frame_valid, err, h_rd_r, y_rd_r);
    end else $display("rst_midload: outputs idle");
    drive_frame(z, 8, 1'b0);
    check_head("rst_next");
    release_head("rst_next");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_y_early();
    test_both_full();
    test_restart();
    test_simul_release();
    test_rst_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_soml_input_loader
